// File: rtl/vram_write_arbiter.sv
// VRAM write-port arbiter: CPU byte writes vs. region fill engine.
// CPU wins a slot when buffered; the one-entry buffer leaves fill every other slot.
module vram_write_arbiter #(
  parameter int ADDR_W = 13,
  parameter int DEPTH  = 4800
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_valid,
  output logic              cpu_ready,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_data,
  input  logic              fill_start,
  input  logic              fill_abort,
  input  logic [ADDR_W-1:0] fill_base,
  input  logic [ADDR_W-1:0] fill_len,
  input  logic [7:0]        fill_value,
  output logic              fill_busy,
  output logic              fill_done,
  output logic              cpu_oob,
  input  logic              oob_clr,
  output logic              w_en,
  output logic [ADDR_W-1:0] w_addr,
  output logic [7:0]        w_data
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic              buf_valid;
  logic [ADDR_W-1:0] buf_addr;
  logic [7:0]        buf_data;

  logic [1:0]        state;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] remaining;
  logic [7:0]        value;

  logic              accept;
  logic              in_range;
  logic              fill_slot;
  logic [ADDR_W-1:0] ptr_nxt;

  assign cpu_ready = rst_n & ~buf_valid;
  assign accept    = cpu_valid & cpu_ready;
  assign in_range  = cpu_addr <= LAST;
  // An abort on this edge cancels the fill write it would have issued.
  assign fill_slot = (state == S_FILL) & ~buf_valid & ~fill_abort;
  assign ptr_nxt   = (ptr == LAST) ? '0 : ptr + ONE;

  assign fill_busy = (state == S_FILL);
  assign fill_done = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_valid <= 1'b0;
      buf_addr  <= '0;
      buf_data  <= '0;
    end else if (accept && in_range) begin
      buf_valid <= 1'b1;
      buf_addr  <= cpu_addr;
      buf_data  <= cpu_data;
    end else begin
      buf_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_oob <= 1'b0;
    end else if (accept && !in_range) begin
      cpu_oob <= 1'b1;
    end else if (oob_clr) begin
      cpu_oob <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_en   <= 1'b0;
      w_addr <= '0;
      w_data <= '0;
    end else begin
      w_en <= buf_valid | fill_slot;
      if (buf_valid) begin
        w_addr <= buf_addr;
        w_data <= buf_data;
      end else if (fill_slot) begin
        w_addr <= ptr;
        w_data <= value;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      ptr       <= '0;
      remaining <= '0;
      value     <= '0;
    end else begin
      unique case (1'b1)
        state == S_IDLE: begin
          if (fill_start) begin
            value     <= fill_value;
            ptr       <= (fill_base > LAST) ? '0 : fill_base;
            remaining <= fill_len;
            state     <= (fill_len == '0) ? S_DONE : S_FILL;
          end
        end
        state == S_FILL: begin
          if (fill_abort) begin
            state <= S_DONE;
          end else if (!buf_valid) begin
            ptr       <= ptr_nxt;
            remaining <= remaining - ONE;
            if (remaining == ONE) state <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vram_write_arbiter.sv
// Randomized self-checking bench for vram_write_arbiter.
// Keeps a RAM image fed by the write port and a plain reference of expected writes.
module tb_vram_write_arbiter;
  localparam int AW = 13;
  localparam int DEPTH = 4800;

  logic          clk = 0;
  logic          rst_n = 0;
  logic          cpu_valid = 0;
  logic          cpu_ready;
  logic [AW-1:0] cpu_addr = '0;
  logic [7:0]    cpu_data = '0;
  logic          fill_start = 0;
  logic          fill_abort = 0;
  logic [AW-1:0] fill_base = '0;
  logic [AW-1:0] fill_len = '0;
  logic [7:0]    fill_value = '0;
  logic          fill_busy;
  logic          fill_done;
  logic          cpu_oob;
  logic          oob_clr = 0;
  logic          w_en;
  logic [AW-1:0] w_addr;
  logic [7:0]    w_data;

  int total = 0;
  int bad = 0;
  int nw = 0;
  logic [7:0] mem [8192];

  vram_write_arbiter #(.ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_valid(cpu_valid), .cpu_ready(cpu_ready),
    .cpu_addr(cpu_addr), .cpu_data(cpu_data),
    .fill_start(fill_start), .fill_abort(fill_abort),
    .fill_base(fill_base), .fill_len(fill_len),
    .fill_value(fill_value), .fill_busy(fill_busy),
    .fill_done(fill_done), .cpu_oob(cpu_oob),
    .oob_clr(oob_clr), .w_en(w_en),
    .w_addr(w_addr), .w_data(w_data)
  );

  always #5 clk = ~clk;

  // RAM model: commits what the write port presents at the edge.
  always @(posedge clk) begin
    if (w_en === 1'b1) begin
      mem[w_addr] <= w_data;
      nw = nw + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (3) tick();
    total++;
    if ({w_en, w_addr, w_data, fill_busy, fill_done, cpu_oob, cpu_ready} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got en=%b a=%h d=%h busy=%b done=%b oob=%b rdy=%b want all 0",
               w_en, w_addr, w_data, fill_busy, fill_done, cpu_oob, cpu_ready);
    end
    #2 rst_n = 1;
    tick();
    total++;
    if (cpu_ready !== 1'b1) begin
      bad++;
      $display("FAIL ready_after_reset got %b want 1", cpu_ready);
    end
  endtask

  task automatic test_cpu_write();
    logic [AW-1:0] a;
    logic [7:0] d;
    for (int i = 0; i < 6; i++) begin
      a = (i == 0) ? AW'(12'h012) : AW'($urandom_range(DEPTH - 1));
      d = (i == 0) ? 8'hA5 : 8'($urandom);
      cpu_valid = 1; cpu_addr = a; cpu_data = d;
      tick();
      cpu_valid = 0;
      total++;
      if (cpu_ready !== 1'b0) begin
        bad++;
        $display("FAIL cpu_ready_busy[%0d] got %b want 0", i, cpu_ready);
      end
      tick();
      total++;
      if (w_en !== 1'b1 || w_addr !== a || w_data !== d) begin
        bad++;
        $display("FAIL cpu_issue[%0d] got en=%b a=%h d=%h want en=1 a=%h d=%h",
                 i, w_en, w_addr, w_data, a, d);
      end
      tick();
      total++;
      if (w_en !== 1'b0 || mem[a] !== d) begin
        bad++;
        $display("FAIL cpu_commit[%0d] got en=%b ram=%h want en=0 ram=%h", i, w_en, mem[a], d);
      end
    end
  endtask

  task automatic test_fill(input int base, input int len, input logic [7:0] val);
    int j, ndone, done_c, errs, start, exp_a, exp_done;
    j = 0; ndone = 0; done_c = -1; errs = 0;
    start = (base >= DEPTH) ? 0 : base;
    fill_start = 1; fill_base = AW'(base); fill_len = AW'(len); fill_value = val;
    tick();
    fill_start = 0;
    total++;
    if (fill_busy !== (len != 0)) begin
      bad++;
      $display("FAIL fill_busy_start(b=%0d l=%0d) got %b want %b", base, len, fill_busy, len != 0);
    end
    for (int c = 0; c <= len + 4; c++) begin
      if (w_en === 1'b1) begin
        exp_a = (start + j) % DEPTH;
        if (w_addr !== AW'(exp_a) || w_data !== val || c != j + 1) begin
          if (errs == 0)
            $display("FAIL fill_seq(b=%0d l=%0d) write %0d cyc %0d got a=%0d d=%h want a=%0d d=%h cyc %0d",
                     base, len, j, c, w_addr, w_data, exp_a, val, j + 1);
          errs++;
        end
        j++;
      end
      if (fill_done === 1'b1) begin
        ndone++;
        done_c = c;
      end
      tick();
    end
    exp_done = (len == 0) ? 0 : len;
    total++;
    if (errs != 0) bad++;
    total++;
    if (j != len) begin
      bad++;
      $display("FAIL fill_count(b=%0d l=%0d) got %0d want %0d", base, len, j, len);
    end
    total++;
    if (ndone != 1 || done_c != exp_done) begin
      bad++;
      $display("FAIL fill_done(b=%0d l=%0d) got pulses=%0d at %0d want 1 at %0d",
               base, len, ndone, done_c, exp_done);
    end
    total++;
    if (fill_busy !== 1'b0) begin
      bad++;
      $display("FAIL fill_busy_end got %b want 0", fill_busy);
    end
  endtask

  task automatic test_back_to_back();
    int base, acc, nw0, done_c, errs, ferrs, a;
    logic [7:0] val;
    logic [7:0] exp_m [8192];
    bit touched [8192];
    logic rdy;
    for (int i = 0; i < 8192; i++) touched[i] = 0;
    base = $urandom_range(DEPTH - 1);
    val = 8'($urandom);
    acc = 0; done_c = -1; errs = 0; ferrs = 0;
    nw0 = nw;
    do a = $urandom_range(DEPTH - 1); while (((a - base + DEPTH) % DEPTH) < 100);
    cpu_valid = 1; cpu_addr = AW'(a); cpu_data = 8'($urandom);
    fill_start = 1; fill_base = AW'(base); fill_len = AW'(100); fill_value = val;
    for (int c = 0; c < 400 && done_c < 0; c++) begin
      rdy = cpu_ready;
      tick();
      fill_start = 0;
      if (rdy === 1'b1) begin
        exp_m[cpu_addr] = cpu_data;
        touched[cpu_addr] = 1;
        acc++;
        do a = $urandom_range(DEPTH - 1); while (((a - base + DEPTH) % DEPTH) < 100);
        cpu_addr = AW'(a); cpu_data = 8'($urandom);
      end
      if (fill_done === 1'b1) done_c = c;
    end
    cpu_valid = 0;
    repeat (3) tick();
    total++;
    if (done_c < 198 || done_c > 202) begin
      bad++;
      $display("FAIL mixed_fill_time got %0d want 200+-2", done_c);
    end
    for (int i = 0; i < DEPTH; i++)
      if (touched[i] && mem[i] !== exp_m[i]) errs++;
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL mixed_cpu_data got %0d wrong bytes want 0", errs);
    end
    for (int i = 0; i < 100; i++)
      if (mem[(base + i) % DEPTH] !== val) ferrs++;
    total++;
    if (ferrs != 0) begin
      bad++;
      $display("FAIL mixed_fill_data got %0d wrong bytes want 0", ferrs);
    end
    total++;
    if (nw - nw0 != acc + 100) begin
      bad++;
      $display("FAIL mixed_write_count got %0d want %0d", nw - nw0, acc + 100);
    end
  endtask

  task automatic test_abort();
    int nw0;
    fill_start = 1; fill_base = AW'($urandom_range(DEPTH - 1));
    fill_len = AW'($urandom_range(50, 10)); fill_value = 8'($urandom);
    tick();
    fill_start = 0;
    nw0 = nw;
    tick();
    tick();
    fill_abort = 1;
    tick();
    fill_abort = 0;
    total++;
    if (w_en !== 1'b0 || fill_done !== 1'b1 || fill_busy !== 1'b0) begin
      bad++;
      $display("FAIL abort_edge got en=%b done=%b busy=%b want 0 1 0", w_en, fill_done, fill_busy);
    end
    fill_start = 1; fill_len = AW'(5);
    tick();
    fill_start = 0;
    total++;
    if (fill_busy !== 1'b0 || fill_done !== 1'b0) begin
      bad++;
      $display("FAIL start_in_done got busy=%b done=%b want 0 0", fill_busy, fill_done);
    end
    repeat (10) tick();
    total++;
    if (nw - nw0 != 2) begin
      bad++;
      $display("FAIL abort_writes got %0d want 2", nw - nw0);
    end
  endtask

  task automatic test_oob();
    int nw0;
    nw0 = nw;
    cpu_valid = 1; cpu_addr = AW'($urandom_range(8191, DEPTH)); cpu_data = 8'($urandom);
    tick();
    cpu_valid = 0;
    total++;
    if (cpu_oob !== 1'b1 || cpu_ready !== 1'b1) begin
      bad++;
      $display("FAIL oob_set got oob=%b rdy=%b want 1 1", cpu_oob, cpu_ready);
    end
    repeat (5) tick();
    total++;
    if (cpu_oob !== 1'b1 || nw != nw0) begin
      bad++;
      $display("FAIL oob_sticky got oob=%b writes=%0d want 1 0", cpu_oob, nw - nw0);
    end
    oob_clr = 1;
    tick();
    oob_clr = 0;
    total++;
    if (cpu_oob !== 1'b0) begin
      bad++;
      $display("FAIL oob_clr got %b want 0", cpu_oob);
    end
    cpu_valid = 1; cpu_addr = AW'(DEPTH); oob_clr = 1;
    tick();
    cpu_valid = 0; oob_clr = 0;
    total++;
    if (cpu_oob !== 1'b1) begin
      bad++;
      $display("FAIL oob_set_wins got %b want 1", cpu_oob);
    end
    oob_clr = 1;
    tick();
    oob_clr = 0;
  endtask

  task automatic test_reset_midfill();
    int nw0;
    fill_start = 1; fill_base = AW'($urandom_range(DEPTH - 1));
    fill_len = AW'(50); fill_value = 8'($urandom | 1);
    tick();
    fill_start = 0;
    cpu_valid = 1; cpu_addr = AW'($urandom_range(DEPTH - 1)); cpu_data = 8'hFF;
    repeat (5) tick();
    rst_n = 0;
    #1;
    total++;
    if ({w_en, w_addr, w_data, fill_busy, fill_done, cpu_oob, cpu_ready} !== '0) begin
      bad++;
      $display("FAIL reset_midfill got en=%b a=%h d=%h busy=%b done=%b oob=%b rdy=%b want all 0",
               w_en, w_addr, w_data, fill_busy, fill_done, cpu_oob, cpu_ready);
    end
    cpu_valid = 0;
    repeat (2) tick();
    #2 rst_n = 1;
    nw0 = nw;
    repeat (10) tick();
    total++;
    if (nw != nw0 || fill_busy !== 1'b0) begin
      bad++;
      $display("FAIL after_reset got writes=%0d busy=%b want 0 0", nw - nw0, fill_busy);
    end
  endtask

  initial begin
    test_reset();
    test_cpu_write();
    test_fill(10, 4, 8'h20);
    test_fill(4798, 4, 8'h3C);
    test_fill(5000, 3, 8'h77);
    test_fill(123, 0, 8'h11);
    for (int i = 0; i < 3; i++)
      test_fill($urandom_range(DEPTH - 1), $urandom_range(40, 1), 8'($urandom));
    test_fill($urandom_range(DEPTH - 1), DEPTH + 3, 8'($urandom));
    test_back_to_back();
    test_abort();
    test_oob();
    test_reset_midfill();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got no finish want finish");
    $fatal(1);
  end
endmodule

// File: doc/vram_write_arbiter.md
Name: vram_write_arbiter

Overview:
Single-clock write-port controller for the VGA dual-port video RAM. Arbitrates CPU byte writes against an internal fill engine, which clears or paints a contiguous VRAM region. Drives the RAM write port (w_en/w_addr/w_data) from registered outputs. CPU writes have priority; the fill engine is guaranteed at least one slot in every two cycles.

Parameters:
ADDR_W, 13, width of every VRAM address (matches RAM write-port address width)
DEPTH, 4800, number of valid VRAM bytes; legal addresses are 0..DEPTH-1

Ports:
clk  in  1  system clock; the RAM write clock is tied to it
rst_n  in  1  asynchronous, active-low reset
cpu_valid  in  1  CPU write request
cpu_ready  out  1  CPU request accepted this cycle when cpu_valid is also high
cpu_addr  in  ADDR_W  CPU write address
cpu_data  in  8  CPU write data
fill_start  in  1  one-cycle pulse that starts a fill
fill_abort  in  1  stops an active fill
fill_base  in  ADDR_W  first fill address, sampled on fill_start
fill_len  in  ADDR_W  number of bytes to write, sampled on fill_start
fill_value  in  8  fill byte, sampled on fill_start
fill_busy  out  1  high while a fill is in progress
fill_done  out  1  one-cycle pulse when a fill completes or aborts
cpu_oob  out  1  sticky flag: a CPU address >= DEPTH was seen
oob_clr  in  1  clears cpu_oob
w_en  out  1  RAM write enable
w_addr  out  ADDR_W  RAM write address
w_data  out  8  RAM write data

Behaviour:
- Clocking and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values: w_en=0, w_addr=0, w_data=0, fill_busy=0, fill_done=0, cpu_oob=0. The CPU buffer and fill state are cleared and the FSM enters IDLE.
- cpu_ready = rst_n AND NOT buf_valid. It is combinational from the register only; there is no path from cpu_valid.
- CPU accept (cpu_valid & cpu_ready at edge k):
  - addr/data are loaded into a one-entry buffer and buf_valid is set.
  - If cpu_addr >= DEPTH, the request is still accepted, but it is discarded (buf_valid stays 0) and cpu_oob is set.
- Issue stage (registered, updated every edge):
  - If buf_valid: issue the CPU entry (w_en=1) and clear buf_valid.
  - Otherwise, if FSM is FILL: issue a fill write.
  - Otherwise: w_en=0. w_addr/w_data hold their last values.
- Latency: a CPU write accepted at edge k has w_en high after edge k+1; the RAM commits it at edge k+2. Maximum CPU throughput is one write per 2 cycles, so fill gets at least 50% of slots.
- Ordering: CPU writes issue in acceptance order. A CPU write to an address the fill reaches later is overwritten by the fill; this is intended.
- FSM states:
  - IDLE: on fill_start, latch base/len/value. len=0 goes to DONE; otherwise go to FILL with ptr=base, remaining=len. fill_start in any other state is ignored.
  - FILL: fill_busy=1.
    - Each fill slot writes fill_value at ptr, then ptr increments and remaining decrements.
    - ptr wraps DEPTH-1 -> 0. A base >= DEPTH is reduced to 0 at latch.
    - After the write with remaining=1 is issued, go to DONE.
    - fill_abort goes to DONE immediately; a fill write issued on that same edge is suppressed.
  - DONE: fill_done=1 for exactly one cycle, fill_busy=0, then IDLE.
- cpu_oob:
  - oob_clr clears it.
  - If oob_clr and a new out-of-bounds accept occur on the same edge, set wins.
- fill_len > DEPTH is legal: addresses wrap and rewrite.
- Reset mid-fill or mid-CPU-write: the pending write is dropped. No partial w_en is asserted after rst_n rises.

Test Plan:
- Reset release, then a CPU write addr=0x012, data=0xA5 at edge 1 -> cpu_ready=0 during cycle 1. w_en=1, w_addr=0x012, w_data=0xA5 after edge 2. Readback 0xA5 via the RAM read port.
- Fill base=10, len=4, value=0x20, no CPU traffic -> w_en high for 4 consecutive cycles at addresses 10,11,12,13. fill_done pulses once; fill_busy then low.
- Fill base=4798, len=4, DEPTH=4800 -> writes go to 4798, 4799, 0, 1.
- Fill len=100 with a CPU request every cycle -> writes alternate CPU and fill. The fill completes in 200 cycles ±2, and all CPU data lands at the correct addresses.
- fill_abort on the third fill write -> exactly 2 fill writes are committed. fill_done pulses the next cycle; a fill_start during DONE is ignored.
- Out-of-bounds and mid-fill reset:
  - CPU addr=4800 -> no w_en, cpu_oob=1; it stays set until oob_clr.
  - fill_len=0 -> fill_done pulses with no writes.
  - rst_n low mid-fill -> all outputs 0 immediately.
